// File: rtl/cardinal_nic_pkg.sv
// Shared constants and types for the Cardinal node network interface.
package cardinal_nic_pkg;

  localparam int unsigned PKT_W      = 64;
  localparam int unsigned PKT_VC_BIT = 0;

  // Processor-visible register map
  localparam logic [1:0] NIC_IN_DATA  = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_DATA = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  // Packets are numbered big-endian: bit 0 is the MSB and carries the VC bit.
  typedef logic [0:PKT_W-1] pkt_t;

  // Extract the virtual-channel bit a packet travels on.
  function automatic logic pkt_vc(input pkt_t pkt);
    return pkt[PKT_VC_BIT];
  endfunction

  // Status word: flag in the least significant position (bit 63), zeros elsewhere.
  function automatic pkt_t status_word(input logic flag);
    return {{(PKT_W-1){1'b0}}, flag};
  endfunction

endpackage

// File: rtl/nic_slot.sv
// Single-entry packet buffer with a full flag. Unload wins over load; the
// parent never asserts load while full, so the two cannot both be useful.
module nic_slot
  import cardinal_nic_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic unload_i,
  input  pkt_t data_i,
  output logic full_o,
  output pkt_t data_o
);

  logic full_q, full_d;
  pkt_t data_q, data_d;

  // Next-state: clear on unload, capture on load, otherwise hold.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (unload_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
      data_d = data_i;
    end else begin
      full_d = full_q;
      data_d = data_q;
    end
  end

  // State register; reset discards any held packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/cardinal_node_nic.sv
// Memory-mapped NIC for one Cardinal node: one input and one output slot,
// processor register decode, and even/odd polarity gating of outbound sends.
module cardinal_node_nic
  import cardinal_nic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [0:1] addr,
  input  pkt_t       d_in,
  output pkt_t       d_out,
  input  logic       nicEn,
  input  logic       nicWrEn,
  input  logic       net_si,
  output logic       net_ri,
  input  pkt_t       net_di,
  output logic       net_so,
  input  logic       net_ro,
  output pkt_t       net_do,
  input  logic       net_polarity
);

  logic rd_en_s;
  logic wr_en_s;
  logic in_full_s;
  logic out_full_s;
  pkt_t in_buf_s;
  pkt_t out_buf_s;
  logic in_load_s;
  logic in_unload_s;
  logic out_load_s;

  assign rd_en_s = nicEn & ~nicWrEn;
  assign wr_en_s = nicEn & nicWrEn;

  // Router side of the input slot: accept only while empty.
  assign net_ri    = ~in_full_s;
  assign in_load_s = net_si & ~in_full_s;
  // Reading the data register pops the slot, but only when something is there.
  assign in_unload_s = rd_en_s & (addr == NIC_IN_DATA) & in_full_s;

  // A write to a full output slot is dropped; software polls status first.
  assign out_load_s = wr_en_s & (addr == NIC_OUT_DATA) & ~out_full_s;
  // Send only on the phase matching the packet's VC bit.
  assign net_so = out_full_s & net_ro & (pkt_vc(out_buf_s) == net_polarity);
  assign net_do = out_buf_s;

  nic_slot u_in_slot (
    .clk      (clk),
    .reset    (reset),
    .load_i   (in_load_s),
    .unload_i (in_unload_s),
    .data_i   (net_di),
    .full_o   (in_full_s),
    .data_o   (in_buf_s)
  );

  nic_slot u_out_slot (
    .clk      (clk),
    .reset    (reset),
    .load_i   (out_load_s),
    .unload_i (net_so),
    .data_i   (d_in),
    .full_o   (out_full_s),
    .data_o   (out_buf_s)
  );

  // Processor read mux; zero when not reading or reading the output data register.
  always_comb begin
    d_out = '0;
    if (rd_en_s) begin
      case (addr)
        NIC_IN_DATA:  d_out = in_buf_s;
        NIC_IN_STAT:  d_out = status_word(in_full_s);
        NIC_OUT_STAT: d_out = status_word(out_full_s);
        default:      d_out = '0;
      endcase
    end else begin
      d_out = '0;
    end
  end

endmodule

// File: tb/tb_cardinal_node_nic.sv
// Directed, self-checking bench for cardinal_node_nic with an output scoreboard.
module tb_cardinal_node_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int n_tests = 0;
  int n_fail  = 0;
  logic [0:63] exp_q[$];

  cardinal_node_nic dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [0:63] obs, input logic [0:63] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cpu();
    nicEn = 1'b0; nicWrEn = 1'b0; addr = 2'b00; d_in = 64'h0;
  endtask

  task automatic cpu_read(input logic [1:0] a);
    nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [0:63] v);
    nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = v;
  endtask

  // Scoreboard: every cycle with net_so high is one send, checked against the queue.
  always @(negedge clk) begin
    if (net_so === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_send", net_do, 64'hX);
      end else begin
        check("send_data", net_do, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; idle_cpu();
    net_si = 1'b0; net_di = 64'h0; net_ro = 1'b0; net_polarity = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    @(negedge clk);
    check("rst_net_ri", {63'h0, net_ri}, 64'h1);
    check("rst_net_so", {63'h0, net_so}, 64'h0);
    check("rst_net_do", net_do, 64'h0);
    check("rst_d_out",  d_out, 64'h0);
    cyc(); cpu_read(2'b01);
    @(negedge clk); check("rst_in_stat", d_out, 64'h0);

    // Input path
    cyc(); idle_cpu(); net_si = 1'b1; net_di = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk); check("in_ri_before", {63'h0, net_ri}, 64'h1);
    cyc(); net_si = 1'b0; cpu_read(2'b01);
    @(negedge clk);
    check("in_ri_full", {63'h0, net_ri}, 64'h0);
    check("in_stat_full", d_out, 64'h1);
    cyc(); cpu_read(2'b00);
    @(negedge clk); check("in_data", d_out, 64'hDEAD_BEEF_0000_0001);
    cyc(); cpu_read(2'b01);
    @(negedge clk);
    check("in_ri_after", {63'h0, net_ri}, 64'h1);
    check("in_stat_empty", d_out, 64'h0);
    cyc(); cpu_read(2'b00);
    @(negedge clk); check("in_stale_read", d_out, 64'hDEAD_BEEF_0000_0001);
    cyc(); idle_cpu();
    @(negedge clk); check("in_stale_no_effect", {63'h0, net_ri}, 64'h1);

    // Input backpressure
    cyc(); net_si = 1'b1; net_di = 64'h1111_2222_3333_4444;
    cyc(); net_di = 64'h5555_6666_7777_8888;
    cyc(); cpu_read(2'b00);
    @(negedge clk);
    check("inbp_ri", {63'h0, net_ri}, 64'h0);
    check("inbp_first", d_out, 64'h1111_2222_3333_4444);
    cyc(); idle_cpu();
    @(negedge clk); check("inbp_ri_reopen", {63'h0, net_ri}, 64'h1);
    cyc(); net_si = 1'b0; cpu_read(2'b00);
    @(negedge clk);
    check("inbp_ri_again", {63'h0, net_ri}, 64'h0);
    check("inbp_second", d_out, 64'h5555_6666_7777_8888);
    cyc(); idle_cpu();

    // Output path with polarity
    net_ro = 1'b1; net_polarity = 1'b0;
    cpu_write(2'b10, 64'hA5A5_0000_0000_0000);
    exp_q.push_back(64'hA5A5_0000_0000_0000);
    cyc(); idle_cpu();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pol_hold_so", {63'h0, net_so}, 64'h0);
      cyc();
    end
    @(negedge clk); check("pol_hold_do", net_do, 64'hA5A5_0000_0000_0000);
    cyc(); net_polarity = 1'b1;
    @(negedge clk); check("pol_so", {63'h0, net_so}, 64'h1);
    cyc(); cpu_read(2'b11);
    @(negedge clk);
    check("pol_so_drop", {63'h0, net_so}, 64'h0);
    check("pol_out_stat", d_out, 64'h0);

    // Output backpressure; also a write to a non-output address is ignored
    cyc(); net_ro = 1'b0; cpu_write(2'b00, 64'h0123_4567_89AB_CDEF);
    cyc(); cpu_read(2'b11);
    @(negedge clk); check("ignored_write", d_out, 64'h0);
    cyc(); cpu_write(2'b10, 64'h8000_0000_0000_0B0B);
    exp_q.push_back(64'h8000_0000_0000_0B0B);
    cyc(); cpu_write(2'b10, 64'hC000_0000_0000_0C0C);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_so", {63'h0, net_so}, 64'h0);
      cyc(); idle_cpu();
    end
    cpu_read(2'b11);
    @(negedge clk);
    check("bp_held", net_do, 64'h8000_0000_0000_0B0B);
    check("bp_stat", d_out, 64'h1);
    cyc(); net_ro = 1'b1;
    @(negedge clk); check("bp_release", {63'h0, net_so}, 64'h1);
    cyc();
    @(negedge clk); check("bp_stat_after", d_out, 64'h0);

    // Back-to-back writes, each gated on output status
    net_polarity = 1'b0;
    for (int k = 0; k < 5; k++) begin
      automatic bit ok = 1'b0;
      for (int p = 0; p < 20 && !ok; p++) begin
        cyc(); cpu_read(2'b11);
        @(negedge clk);
        if (d_out === 64'h0) ok = 1'b1;
      end
      check("b2b_poll", {63'h0, ok}, 64'h1);
      cyc(); cpu_write(2'b10, 64'h0000_0000_0000_1000 + 64'(k));
      exp_q.push_back(64'h0000_0000_0000_1000 + 64'(k));
      cyc(); idle_cpu();
      @(negedge clk); check("b2b_first_cycle", {63'h0, net_so}, 64'h1);
    end
    cyc(); cyc();
    check("sb_drained", 64'(exp_q.size()), 64'h0);

    // Asynchronous reset with both buffers full
    net_ro = 1'b0; net_polarity = 1'b1;
    net_si = 1'b1; net_di = 64'hFEED_0000_0000_0001;
    cpu_write(2'b10, 64'h8000_0000_0000_00EE);
    exp_q.push_back(64'h8000_0000_0000_00EE);
    cyc(); net_si = 1'b0; cpu_read(2'b01); net_ro = 1'b1;
    #2;
    check("pre_rst_so", {63'h0, net_so}, 64'h1);
    check("pre_rst_stat", d_out, 64'h1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_ri", {63'h0, net_ri}, 64'h1);
    check("mid_rst_so", {63'h0, net_so}, 64'h0);
    check("mid_rst_d_out", d_out, 64'h0);
    check("mid_rst_do", net_do, 64'h0);
    cyc(); reset = 1'b1; cpu_read(2'b11);
    @(negedge clk); check("post_rst_out_stat", d_out, 64'h0);
    cyc(); idle_cpu();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
